ahb_decoder: RTL and testbench
==============================

Name: ahb_decoder

Overview:
- Address decoder and default slave for the AHB-Lite interconnect; the request-side counterpart of the response mux.
- Decodes the address-phase HADDR into one-hot slave selects.
- Registers a data-phase one-hot select that drives the sel inputs of the response mux (mux4).
- Contains the default slave, which returns the two-cycle ERROR response for unmapped active transfers.

Parameters:
AW, 32, address width
BASE0, 32'h0000_0000, slave 0 base address (compared after masking)
MASK0, 32'hF000_0000, slave 0 compare mask
BASE1, 32'h1000_0000, slave 1 base address
MASK1, 32'hF000_0000, slave 1 compare mask
BASE2, 32'h2000_0000, slave 2 base address
MASK2, 32'hF000_0000, slave 2 compare mask
BASE3, 32'h3000_0000, slave 3 base address
MASK3, 32'hF000_0000, slave 3 compare mask

Ports:
HCLK  input  1  clock
HRESETn  input  1  synchronous reset, active-low
haddr  input  AW  address-phase HADDR from master
htrans  input  2  address-phase HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hready  input  1  global HREADY (mux output fed back)
hsel  output  4  address-phase one-hot slave select (combinational)
hsel_def  output  1  address-phase default-slave select (combinational)
dp_sel  output  4  data-phase one-hot select to response mux sel0..sel3
dp_sel_def  output  1  data-phase select of default-slave response
def_hreadyout  output  1  default slave HREADYOUT
def_hresp  output  1  default slave HRESP (0 OKAY, 1 ERROR)

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is synchronous, active-low. All state is sampled on the rising HCLK edge with HRESETn low.
- Reset values: dp_sel=0, dp_sel_def=1, FSM=IDLE, def_hreadyout=1, def_hresp=0. dp_sel_def=1 at reset guarantees the muxed HREADY is 1 out of reset.
- Region match: slave n matches when (haddr & MASKn) == BASEn.
- Overlapping matches: the lowest index wins, so hsel stays strictly one-hot or zero.
- hsel_def = ~|hsel.
- hsel and hsel_def are pure decode of haddr and do not depend on htrans.
- Data-phase register: when hready=1, {dp_sel_def, dp_sel} <= {hsel_def, hsel}. When hready=0, the values hold.
- The data-phase register always has exactly one bit set among {dp_sel_def, dp_sel}.
- Latency: address-phase decode is 0 cycles; the data-phase select is 1 cycle after hready is accepted.
- Default slave FSM states: IDLE, ERR1, ERR2.
  - active = hready & hsel_def & htrans[1].
  - IDLE: def_hreadyout=1, def_hresp=0. active -> ERR1, otherwise stay in IDLE.
  - ERR1: def_hreadyout=0, def_hresp=1. Unconditionally -> ERR2.
  - ERR2: def_hreadyout=1, def_hresp=1. active -> ERR1 (back-to-back error), otherwise -> IDLE.
- IDLE and BUSY transfers to unmapped space, or any unmapped address with htrans[1]=0, get a zero-wait OKAY: FSM stays in IDLE.
- A master cancelling after ERR1 (driving IDLE) has no effect: the FSM still completes ERR2.
- Reset mid-error (in ERR1 or ERR2) returns to IDLE with the reset values above on the next edge.
- hready=0 while FSM is in IDLE because another slave is stalling: no state change. Accept happens only when hready=1.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP encodings: OKAY=0, ERROR=1.
  - Default-slave state encodings: IDLE=2'b00, ERR1=2'b01, ERR2=2'b10.
- One natural sub-module: ahb_default_slave, containing the FSM and the def_hreadyout/def_hresp outputs, instantiated by ahb_decoder.
- Decode and the data-phase register stay in ahb_decoder.

Test Plan:
- Reset: hold HRESETn=0 for 2 cycles, then release -> dp_sel=4'b0000, dp_sel_def=1, def_hreadyout=1, def_hresp=0.
- Mapped decode: haddr=32'h2000_0040, htrans=NONSEQ, hready=1 -> hsel=4'b0100 same cycle; dp_sel=4'b0100 and dp_sel_def=0 next cycle.
- Stall hold:
  - Accept haddr=32'h1000_0000 (dp_sel=4'b0010), then hold hready=0 for 3 cycles with haddr=32'h3000_0000 -> dp_sel stays 4'b0010.
  - Release hready=1 -> dp_sel becomes 4'b1000 on the next cycle.
- Unmapped error:
  - haddr=32'h8000_0000, htrans=NONSEQ, hready=1 -> next cycle dp_sel_def=1 with def_hreadyout=0, def_hresp=1.
  - Following cycle def_hreadyout=1, def_hresp=1.
  - Then IDLE with def_hreadyout=1, def_hresp=0.
- Back-to-back and non-active:
  - During ERR2, present unmapped SEQ -> FSM returns to ERR1 (def_hreadyout=0).
  - Unmapped htrans=IDLE or BUSY -> def_hreadyout=1, def_hresp=0 with no wait state.
- Overlap and reset mid-error:
  - Set MASK1=32'h0, BASE1=32'h0 (matches everything) and drive haddr=32'h0000_0010 -> hsel=4'b0001, since the lowest index wins.
  - Assert HRESETn=0 while in ERR1 -> next edge def_hresp=0, def_hreadyout=1, dp_sel_def=1.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the decoder and its default slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers active transfers to unmapped space with the
// two-cycle AHB ERROR response, and everything else with zero-wait OKAY.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       hready,
    input  logic       hsel_def,
    input  logic [1:0] htrans,
    output logic       def_hreadyout,
    output logic       def_hresp
);

    ds_state_t state_q;
    logic      trans_active;
    logic      active;

    // Only NONSEQ/SEQ transfers that are accepted on the bus start an error.
    always_comb begin
        trans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
        active       = hready & hsel_def & trans_active;
    end

    // Error FSM with registered HREADYOUT/HRESP; ERR1 always proceeds to ERR2.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= DS_IDLE;
            def_hreadyout <= 1'b1;
            def_hresp     <= HRESP_OKAY;
        end else begin
            unique case (state_q)
                DS_IDLE, DS_ERR2: begin
                    if (active) begin
                        state_q       <= DS_ERR1;
                        def_hreadyout <= 1'b0;
                        def_hresp     <= HRESP_ERROR;
                    end else begin
                        state_q       <= DS_IDLE;
                        def_hreadyout <= 1'b1;
                        def_hresp     <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state_q       <= DS_ERR2;
                    def_hreadyout <= 1'b1;
                    def_hresp     <= HRESP_ERROR;
                end
                default: begin
                    state_q       <= DS_IDLE;
                    def_hreadyout <= 1'b1;
                    def_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder: one-hot address-phase selects, registered
// data-phase selects for the response mux, and the default slave.
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter int unsigned    AW    = 32,
    parameter logic [AW-1:0]  BASE0 = 32'h0000_0000,
    parameter logic [AW-1:0]  MASK0 = 32'hF000_0000,
    parameter logic [AW-1:0]  BASE1 = 32'h1000_0000,
    parameter logic [AW-1:0]  MASK1 = 32'hF000_0000,
    parameter logic [AW-1:0]  BASE2 = 32'h2000_0000,
    parameter logic [AW-1:0]  MASK2 = 32'hF000_0000,
    parameter logic [AW-1:0]  BASE3 = 32'h3000_0000,
    parameter logic [AW-1:0]  MASK3 = 32'hF000_0000
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hready,
    output logic [3:0]    hsel,
    output logic          hsel_def,
    output logic [3:0]    dp_sel,
    output logic          dp_sel_def,
    output logic          def_hreadyout,
    output logic          def_hresp
);

    logic [3:0] match;

    // Raw region matches; overlaps are resolved below.
    always_comb begin
        match[0] = (haddr & MASK0) == BASE0;
        match[1] = (haddr & MASK1) == BASE1;
        match[2] = (haddr & MASK2) == BASE2;
        match[3] = (haddr & MASK3) == BASE3;
    end

    // Lowest matching index wins so hsel is one-hot or zero; decode ignores htrans.
    always_comb begin
        hsel = '0;
        if (match[0])      hsel[0] = 1'b1;
        else if (match[1]) hsel[1] = 1'b1;
        else if (match[2]) hsel[2] = 1'b1;
        else if (match[3]) hsel[3] = 1'b1;
        hsel_def = ~|hsel;
    end

    // Data-phase select advances only on accepted transfers; reset selects the
    // default slave so the muxed HREADY is high out of reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_sel     <= '0;
            dp_sel_def <= 1'b1;
        end else if (hready) begin
            dp_sel     <= hsel;
            dp_sel_def <= hsel_def;
        end
    end

    ahb_default_slave u_def (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .hready        (hready),
        .hsel_def      (hsel_def),
        .htrans        (htrans),
        .def_hreadyout (def_hreadyout),
        .def_hresp     (def_hresp)
    );

endmodule

// File: tb/tb_ahb_decoder.sv
// Directed bench for ahb_decoder: decode table plus hand-written error,
// stall and reset sequences, and an overlapping-map instance.
module tb_ahb_decoder;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;

    logic [3:0]  hsel, dp_sel;
    logic        hsel_def, dp_sel_def, def_hreadyout, def_hresp;

    logic [3:0]  o_hsel, o_dp_sel;
    logic        o_hsel_def, o_dp_sel_def, o_hreadyout, o_hresp;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_decoder u_dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .haddr         (haddr),
        .htrans        (htrans),
        .hready        (hready),
        .hsel          (hsel),
        .hsel_def      (hsel_def),
        .dp_sel        (dp_sel),
        .dp_sel_def    (dp_sel_def),
        .def_hreadyout (def_hreadyout),
        .def_hresp     (def_hresp)
    );

    // Slave 1 matches every address; slave 0 must still win its own region.
    ahb_decoder #(
        .AW    (32),
        .BASE1 (32'h0000_0000),
        .MASK1 (32'h0000_0000)
    ) u_ovl (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .haddr         (haddr),
        .htrans        (htrans),
        .hready        (hready),
        .hsel          (o_hsel),
        .hsel_def      (o_hsel_def),
        .dp_sel        (o_dp_sel),
        .dp_sel_def    (o_dp_sel_def),
        .def_hreadyout (o_hreadyout),
        .def_hresp     (o_hresp)
    );

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  exp_hsel;
        logic        exp_def;
    } dec_vec_t;

    dec_vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Checks the registered outputs: data-phase select and default slave response.
    task automatic check_dp(input string name, input logic [3:0] e_sel, input logic e_def,
                            input logic e_rdy, input logic e_resp);
        check({name, ".dp_sel"},        {28'b0, dp_sel},        {28'b0, e_sel});
        check({name, ".dp_sel_def"},    {31'b0, dp_sel_def},    {31'b0, e_def});
        check({name, ".def_hreadyout"}, {31'b0, def_hreadyout}, {31'b0, e_rdy});
        check({name, ".def_hresp"},     {31'b0, def_hresp},     {31'b0, e_resp});
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 4'b0001, 1'b0};
        vecs[1] = '{32'h0FFF_FFFF, 4'b0001, 1'b0};
        vecs[2] = '{32'h1000_0000, 4'b0010, 1'b0};
        vecs[3] = '{32'h1ABC_DEF0, 4'b0010, 1'b0};
        vecs[4] = '{32'h2000_0040, 4'b0100, 1'b0};
        vecs[5] = '{32'h3FFF_FFFC, 4'b1000, 1'b0};
        vecs[6] = '{32'h4000_0000, 4'b0000, 1'b1};
        vecs[7] = '{32'h8000_0000, 4'b0000, 1'b1};
        vecs[8] = '{32'hFFFF_FFFF, 4'b0000, 1'b1};
        vecs[9] = '{32'hF000_0000, 4'b0000, 1'b1};

        // Reset held for two edges
        HRESETn = 1'b0;
        haddr   = 32'h0;
        htrans  = T_IDLE;
        hready  = 1'b1;
        tick();
        tick();
        HRESETn = 1'b1;
        check_dp("reset", 4'b0000, 1'b1, 1'b1, 1'b0);

        // Combinational decode table; hready low so nothing is accepted
        hready = 1'b0;
        htrans = T_NONSEQ;
        for (int i = 0; i < 10; i++) begin
            haddr = vecs[i].addr;
            #1;
            check($sformatf("dec%0d.hsel", i), {28'b0, hsel}, {28'b0, vecs[i].exp_hsel});
            check($sformatf("dec%0d.hsel_def", i), {31'b0, hsel_def}, {31'b0, vecs[i].exp_def});
        end
        tick();
        check_dp("no_accept", 4'b0000, 1'b1, 1'b1, 1'b0);

        // Mapped decode with one-cycle data-phase latency
        haddr  = 32'h2000_0040;
        htrans = T_NONSEQ;
        hready = 1'b1;
        #1;
        check("mapped.hsel", {28'b0, hsel}, 32'h4);
        tick();
        check_dp("mapped", 4'b0100, 1'b0, 1'b1, 1'b0);

        // Stall holds the data-phase select
        haddr = 32'h1000_0000;
        tick();
        check_dp("stall.accept", 4'b0010, 1'b0, 1'b1, 1'b0);
        hready = 1'b0;
        haddr  = 32'h3000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_dp($sformatf("stall.hold%0d", i), 4'b0010, 1'b0, 1'b1, 1'b0);
        end
        hready = 1'b1;
        tick();
        check_dp("stall.release", 4'b1000, 1'b0, 1'b1, 1'b0);

        // Unmapped NONSEQ: ERR1, ERR2 (master cancels with IDLE), then IDLE
        haddr  = 32'h8000_0000;
        htrans = T_NONSEQ;
        tick();
        check_dp("err.err1", 4'b0000, 1'b1, 1'b0, 1'b1);
        hready = 1'b0;
        haddr  = 32'h0;
        htrans = T_IDLE;
        tick();
        check_dp("err.err2", 4'b0000, 1'b1, 1'b1, 1'b1);
        hready = 1'b1;
        tick();
        check_dp("err.idle", 4'b0001, 1'b0, 1'b1, 1'b0);

        // Back-to-back error: unmapped SEQ during ERR2
        haddr  = 32'h8000_0000;
        htrans = T_NONSEQ;
        tick();
        check_dp("b2b.err1a", 4'b0000, 1'b1, 1'b0, 1'b1);
        hready = 1'b0;
        tick();
        check_dp("b2b.err2a", 4'b0000, 1'b1, 1'b1, 1'b1);
        hready = 1'b1;
        haddr  = 32'h9000_0000;
        htrans = T_SEQ;
        tick();
        check_dp("b2b.err1b", 4'b0000, 1'b1, 1'b0, 1'b1);
        hready = 1'b0;
        htrans = T_IDLE;
        tick();
        check_dp("b2b.err2b", 4'b0000, 1'b1, 1'b1, 1'b1);
        hready = 1'b1;
        tick();
        check_dp("b2b.idle", 4'b0000, 1'b1, 1'b1, 1'b0);

        // Non-active unmapped transfers get zero-wait OKAY
        htrans = T_IDLE;
        tick();
        check_dp("okay.idle", 4'b0000, 1'b1, 1'b1, 1'b0);
        htrans = T_BUSY;
        tick();
        check_dp("okay.busy", 4'b0000, 1'b1, 1'b1, 1'b0);
        htrans = T_NONSEQ;
        hready = 1'b0;
        tick();
        check_dp("okay.stalled", 4'b0000, 1'b1, 1'b1, 1'b0);

        // Reset asserted while in ERR1
        hready = 1'b1;
        tick();
        check_dp("rst.err1", 4'b0000, 1'b1, 1'b0, 1'b1);
        haddr   = 32'h1000_0000;
        HRESETn = 1'b0;
        tick();
        check_dp("rst.mid", 4'b0000, 1'b1, 1'b1, 1'b0);
        HRESETn = 1'b1;
        htrans  = T_IDLE;
        tick();
        check_dp("rst.after", 4'b0010, 1'b0, 1'b1, 1'b0);

        // Overlapping map: lowest index wins
        haddr = 32'h0000_0010;
        #1;
        check("ovl.low.hsel", {28'b0, o_hsel}, 32'h1);
        haddr = 32'h8000_0000;
        #1;
        check("ovl.high.hsel", {28'b0, o_hsel}, 32'h2);
        check("ovl.high.hsel_def", {31'b0, o_hsel_def}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
